// File: rtl/lcd_write_arbiter_pkg.sv
// Shared LCD definitions: buffer geometry, clear fill character and arbiter state encodings.
package lcd_write_arbiter_pkg;

    localparam int LCD_CHARS = 32;
    localparam int LOC_W     = 5;
    localparam int DATA_W    = 8;

    localparam logic [7:0] LCD_CLEAR_CHAR = 8'h20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_write_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request at or after the priority pointer wins.
module rr_select
    import lcd_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    // Scan requesters starting at ptr, wrapping once around.
    always_comb begin : sel_p
        int   idx;
        logic hit;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        hit    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx         = (int'(ptr) + k) % NUM_REQ;
            hit         = req[idx] & ~found;
            winner[idx] = winner[idx] | hit;
            found       = found | hit;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Arbitrates requester writes into the LCD character buffer and runs whole-screen clears.
module lcd_write_arbiter
    import lcd_write_arbiter_pkg::*;
#(
    parameter int         NUM_REQ    = 3,
    parameter logic [7:0] CLEAR_CHAR = LCD_CLEAR_CHAR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [LOC_W*NUM_REQ-1:0]  reqLocation,
    input  logic [DATA_W*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      clearRequest,
    output logic                      busy,
    output logic                      writeEnable,
    output logic [LOC_W-1:0]          location,
    output logic [DATA_W-1:0]         data
);

    localparam int               PTR_W    = ptr_width(NUM_REQ);
    localparam logic [LOC_W-1:0] LAST_LOC = LOC_W'(LCD_CHARS - 1);

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic [LOC_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                we_q, we_d;
    logic [LOC_W-1:0]    loc_q, loc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  winner_s;
    logic [LOC_W-1:0]    sel_loc_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [PTR_W-1:0]    sel_ptr_s;
    logic                clear_accept_s;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner_s)
    );

    // One-hot AND-OR mux of the winner's slices and its successor pointer.
    always_comb begin
        sel_loc_s  = '0;
        sel_data_s = '0;
        sel_ptr_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_loc_s  |= {LOC_W{winner_s[i]}} & reqLocation[i*LOC_W +: LOC_W];
            sel_data_s |= {DATA_W{winner_s[i]}} & reqData[i*DATA_W +: DATA_W];
            sel_ptr_s  |= winner_s[i] ? PTR_W'((i + 1) % NUM_REQ) : '0;
        end
    end

    assign clear_accept_s = clearRequest & ~busy_q;

    // Next-state and registered-output decode; a pending clear outranks every requester.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        grant_d   = '0;
        we_d      = 1'b0;
        loc_d     = '0;
        data_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d   = ST_CLEAR;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    we_d      = 1'b1;
                    loc_d     = '0;
                    data_d    = CLEAR_CHAR;
                end else if (clear_accept_s) begin
                    pending_d = 1'b1;
                end else if (|req) begin
                    grant_d = winner_s;
                    we_d    = 1'b1;
                    loc_d   = sel_loc_s;
                    data_d  = sel_data_s;
                    ptr_d   = sel_ptr_s;
                end else begin
                    we_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_LOC) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + LOC_W'(1);
                end
                we_d   = 1'b1;
                loc_d  = cnt_d;
                data_d = CLEAR_CHAR;
                // Busy drops together with the final write so arbitration resumes on the next edge.
                if (cnt_d == LAST_LOC) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = pending_d | (state_d == ST_CLEAR);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            we_q      <= 1'b0;
            loc_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            we_q      <= we_d;
            loc_q     <= loc_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign writeEnable = we_q;
    assign location    = loc_q;
    assign data        = data_q;
    assign busy        = busy_q;

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, the number of requesters sharing the character buffer write port.
REQ-002 SHALL have parameter CLEAR_CHAR, default 8'h20, the fill character for a screen clear.
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester write request, held high until granted.
REQ-006 SHALL have port reqLocation  input  5*NUM_REQ  packed character index, 0-31, slice i belongs to requester i.
REQ-007 SHALL have port reqData  input  8*NUM_REQ  packed character byte, slice i belongs to requester i.
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot, one-cycle pulse; the write for requester i occurs this cycle.
REQ-009 SHALL have port clearRequest  input  1  single-cycle pulse that requests all 32 positions be filled with CLEAR_CHAR.
REQ-010 SHALL have port busy  output  1  high while a clear sequence is pending or in progress.
REQ-011 SHALL have port writeEnable  output  1  buffer write strobe to the LCD controller.
REQ-012 SHALL have port location  output  5  buffer write index to the LCD controller.
REQ-013 SHALL have port data  output  8  buffer write byte to the LCD controller.

Function
REQ-014 SHALL be a state machine with states IDLE and CLEAR.
REQ-015 SHALL register all outputs; a request sampled at edge N produces grant and writeEnable during cycle N+1.
REQ-016 SHALL issue at most one write per cycle, and in IDLE SHALL grant a requester whenever any req bit is high (back-to-back grants allowed).
REQ-017 SHALL arbitrate round-robin: a priority pointer starts at requester 0, and after a grant to i it moves to (i+1) mod NUM_REQ.
REQ-018 SHALL drive location and data from the granted requester's slices, sampled at the same edge as req.
REQ-019 SHALL assert grant[i] only in the cycle in which writeEnable is high for that requester's data.
REQ-020 SHALL perform no write and no grant for a req bit that falls before it is granted.
REQ-021 SHALL latch clearRequest into a pending flag; busy SHALL rise in the cycle after the pulse.
REQ-022 SHALL give a pending clear priority over all requesters; IDLE->CLEAR at the next edge, with no grants issued from that edge onward.
REQ-023 In CLEAR, SHALL write CLEAR_CHAR to locations 0,1,...,31 on 32 consecutive cycles, one write per cycle.
REQ-024 SHALL return CLEAR->IDLE after the write to location 31, clear busy in the same cycle, and resume arbitration on the following edge.
REQ-025 SHALL ignore clearRequest pulses that arrive while busy is high; they SHALL neither restart nor extend the sequence.
REQ-026 SHALL, when clearRequest and req arrive at the same edge, start the clear first; the requester waits until the clear ends.
REQ-027 SHALL leave the round-robin pointer unchanged across a clear.
REQ-028 SHALL use a 5-bit clear counter that stops at 31 and does not wrap to 0.

Reset
REQ-029 On reset high, SHALL immediately drive grant=0, writeEnable=0, location=0, data=0 and busy=0.
REQ-030 On reset high, SHALL immediately set the state to IDLE, the pointer to 0, the clear counter to 0 and the pending flag to 0.
REQ-031 SHALL abort a clear in progress on reset, leaving the positions not yet written with their prior contents.

Structure
REQ-032 SHALL take the state encodings, CLEAR_CHAR and LCD_CHARS=32 from the shared lcd package.
REQ-033 SHALL place the round-robin selection (req and pointer in; one-hot winner out) in a combinational sub-module named rr_select.

Verification
REQ-034 Single request: req=3'b010 with loc=5'd7, data=8'h41 -> exactly one cycle with grant=3'b010, writeEnable=1, location=7, data=8'h41.
REQ-035 Contention: req=3'b111 held continuously -> grant order 001,010,100,001 on consecutive cycles.
REQ-036 Clear: a one-cycle clearRequest pulse -> busy high for 32 cycles with writes of 8'h20 to locations 0-31 in order, no grants, then busy low.
REQ-037 Collision: clearRequest and req=3'b001 at the same edge -> the 32 clear writes happen first, then grant=3'b001 in the cycle after busy falls.
REQ-038 Reset mid-clear: reset asserted after the write to location 10 -> outputs zero immediately, and after release no further clear writes occur.
REQ-039 Repeat clear: a second clearRequest during a clear -> exactly 32 clear writes in total.
